// File: rtl/bp_seq_pkg.sv
// Shared types and default sizing for the branch update sequencer slice.
package bp_seq_pkg;

    localparam int DEF_PC_W          = 10;
    localparam int DEF_DEPTH         = 4;
    localparam int DEF_LOOKUP_CYCLES = 4;
    localparam int DEF_UPDATE_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WAIT_RES,
        UPDATE
    } bp_seq_state_e;

    // Width of a cycle counter able to hold the longer of the two windows.
    function automatic int cyc_width(input int lookup_cycles, input int update_cycles);
        int longest;
        longest = (lookup_cycles > update_cycles) ? lookup_cycles : update_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/bp_pc_fifo.sv
// Pending branch-PC queue: valid/ready push side, pop strobe, first-word-fall-through head.
module bp_pc_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ready = !full;
    assign push       = push_valid && !full;
    assign head       = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since only valid entries are read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance on push and pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_update_sequencer.sv
// Lookup/update initiator for the tournament branch predictor: queues PCs,
// holds each for a lookup window, waits for resolution, then drives the update.
module branch_update_sequencer
    import bp_seq_pkg::*;
#(
    parameter int PC_W          = DEF_PC_W,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int LOOKUP_CYCLES = DEF_LOOKUP_CYCLES,
    parameter int UPDATE_CYCLES = DEF_UPDATE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             req_ready,
    output logic [PC_W-1:0]  bp_pc,
    output logic             bp_taken,
    output logic             bp_taken_vld,
    input  logic             bp_pred,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             res_ready,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             busy
);

    localparam int CYC_W = cyc_width(LOOKUP_CYCLES, UPDATE_CYCLES);
    localparam logic [CYC_W-1:0] LAST_LOOKUP = CYC_W'(LOOKUP_CYCLES - 1);
    localparam logic [CYC_W-1:0] LAST_UPDATE = CYC_W'(UPDATE_CYCLES - 1);

    bp_seq_state_e    state;
    logic [CYC_W-1:0] cyc;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  head;
    logic             res_q;
    logic             empty;
    logic             full;
    logic             pop;

    assign pop = (state == IDLE) && !empty;

    bp_pc_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (req_valid),
        .push_ready (req_ready),
        .push_data  (req_pc),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full)
    );

    // pc_q is only reloaded on pop, so bp_pc holds its last value through IDLE.
    assign bp_pc        = pc_q;
    assign res_ready    = (state == WAIT_RES);
    assign bp_taken_vld = (state == UPDATE);
    assign bp_taken     = (state == UPDATE) && res_q;
    assign busy         = (state != IDLE) || !empty;

    // Sequencer FSM with registered prediction, mispredict pulse and saturating count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cyc            <= '0;
            pc_q           <= '0;
            res_q          <= 1'b0;
            pred_taken     <= 1'b0;
            pred_valid     <= 1'b0;
            mispredict     <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            pred_valid <= 1'b0;
            mispredict <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pc_q  <= head;
                        cyc   <= '0;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cyc == LAST_LOOKUP) begin
                        pred_taken <= bp_pred;
                        pred_valid <= 1'b1;
                        state      <= WAIT_RES;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_q <= res_taken;
                        cyc   <= '0;
                        state <= UPDATE;
                        if (res_taken != pred_taken) begin
                            mispredict <= 1'b1;
                            if (mispredict_cnt != '1) begin
                                mispredict_cnt <= mispredict_cnt + 1'b1;
                            end
                        end
                    end
                end
                UPDATE: begin
                    if (cyc == LAST_UPDATE) begin
                        state <= IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_update_sequencer.sv
// Directed bench for branch_update_sequencer: default instance plus a CNT_W=2 instance
// sharing the same stimulus, and a small 2-bit-counter predictor model for learning runs.
module tb_branch_update_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [9:0]  req_pc = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        bp_pred;
    logic        forced_pred = 1'b0;
    logic        use_model = 1'b0;

    logic        req_ready, bp_taken, bp_taken_vld, pred_valid, pred_taken, res_ready, mispredict, busy;
    logic [9:0]  bp_pc;
    logic [15:0] mispredict_cnt;

    logic        req_ready_s, bp_taken_s, bp_taken_vld_s, pred_valid_s, pred_taken_s, res_ready_s, mispredict_s, busy_s;
    logic [9:0]  bp_pc_s;
    logic [1:0]  mispredict_cnt_s;

    int compared = 0;
    int mismatched = 0;

    logic [1:0] ctr [1024];
    logic       vld_prev = 1'b0;

    always #5 clock = ~clock;

    assign bp_pred = use_model ? ctr[bp_pc][1] : forced_pred;

    branch_update_sequencer #(
        .PC_W(10), .DEPTH(4), .LOOKUP_CYCLES(4), .UPDATE_CYCLES(4), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_taken_vld(bp_taken_vld), .bp_pred(bp_pred),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .res_valid(res_valid), .res_taken(res_taken),
        .res_ready(res_ready), .mispredict(mispredict), .mispredict_cnt(mispredict_cnt), .busy(busy)
    );

    branch_update_sequencer #(
        .PC_W(10), .DEPTH(4), .LOOKUP_CYCLES(4), .UPDATE_CYCLES(4), .CNT_W(2)
    ) dut_sat (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready_s),
        .bp_pc(bp_pc_s), .bp_taken(bp_taken_s), .bp_taken_vld(bp_taken_vld_s), .bp_pred(bp_pred),
        .pred_valid(pred_valid_s), .pred_taken(pred_taken_s), .res_valid(res_valid), .res_taken(res_taken),
        .res_ready(res_ready_s), .mispredict(mispredict_s), .mispredict_cnt(mispredict_cnt_s), .busy(busy_s)
    );

    initial begin
        for (int i = 0; i < 1024; i++) ctr[i] = 2'b01;
    end

    // Predictor model: one counter step per update window, on its first cycle.
    always @(posedge clock) begin
        if (use_model && bp_taken_vld && !vld_prev) begin
            if (bp_taken) begin
                if (ctr[bp_pc] != 2'b11) ctr[bp_pc] <= ctr[bp_pc] + 2'b01;
            end else begin
                if (ctr[bp_pc] != 2'b00) ctr[bp_pc] <= ctr[bp_pc] - 2'b01;
            end
        end
        vld_prev <= bp_taken_vld;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [9:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_pred(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (pred_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic resolve(input logic taken);
        res_valid = 1'b1;
        res_taken = taken;
        step();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        repeat (4) step();
        outs = {bp_pc, bp_taken, bp_taken_vld, pred_valid, pred_taken, res_ready, mispredict, busy, req_ready, mispredict_cnt[3:0]};
        compared++;
        if (outs !== 32'h0000_0010) begin
            mismatched++;
            $display("FAIL reset_outputs: got %08h expected %08h", outs, 32'h0000_0010);
        end
        compared++;
        if (mispredict_cnt !== 16'd0 || mispredict_cnt_s !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", mispredict_cnt, mispredict_cnt_s);
        end
        #3 reset = 1'b1;
        #1;
        outs = {bp_pc, bp_taken, bp_taken_vld, pred_valid, pred_taken, res_ready, mispredict, busy, req_ready, mispredict_cnt[3:0]};
        compared++;
        if (outs !== 32'h0000_0010) begin
            mismatched++;
            $display("FAIL release_glitch: got %08h expected %08h", outs, 32'h0000_0010);
        end
        step();
        outs = {bp_pc, bp_taken, bp_taken_vld, pred_valid, pred_taken, res_ready, mispredict, busy, req_ready, mispredict_cnt[3:0]};
        compared++;
        if (outs !== 32'h0000_0010) begin
            mismatched++;
            $display("FAIL post_release: got %08h expected %08h", outs, 32'h0000_0010);
        end
    endtask

    task automatic test_basic();
        forced_pred = 1'b1;
        push(10'h000);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        step();
        // Stray res_valid during lookup must be ignored.
        res_valid = 1'b1;
        res_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({bp_pc, pred_valid, res_ready, bp_taken_vld} !== 13'h000) begin
                mismatched++;
                $display("FAIL basic_lookup[%0d]: got pc=%h pv=%b rr=%b vld=%b expected pc=0 pv=0 rr=0 vld=0",
                         i, bp_pc, pred_valid, res_ready, bp_taken_vld);
            end
            step();
        end
        res_valid = 1'b0;
        compared++;
        if ({pred_valid, pred_taken, res_ready} !== 3'b111) begin
            mismatched++;
            $display("FAIL basic_pred: got pv=%b pt=%b rr=%b expected 1 1 1", pred_valid, pred_taken, res_ready);
        end
        resolve(1'b1);
        compared++;
        if ({mispredict, pred_valid, res_ready} !== 3'b000) begin
            mismatched++;
            $display("FAIL basic_resolve: got mp=%b pv=%b rr=%b expected 0 0 0", mispredict, pred_valid, res_ready);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({bp_taken_vld, bp_taken, bp_pc} !== 12'b11_0000000000) begin
                mismatched++;
                $display("FAIL basic_update[%0d]: got vld=%b tk=%b pc=%h expected 1 1 000", i, bp_taken_vld, bp_taken, bp_pc);
            end
            step();
        end
        compared++;
        if ({bp_taken_vld, bp_taken, busy, mispredict_cnt} !== 19'd0) begin
            mismatched++;
            $display("FAIL basic_end: got vld=%b tk=%b busy=%b cnt=%0d expected 0 0 0 0",
                     bp_taken_vld, bp_taken, busy, mispredict_cnt);
        end
    endtask

    task automatic test_mispredict();
        bit ok;
        forced_pred = 1'b0;
        push(10'h155);
        wait_pred(ok);
        compared++;
        if (!ok || pred_taken !== 1'b0) begin
            mismatched++;
            $display("FAIL misp_pred: got ok=%b pt=%b expected ok=1 pt=0", ok, pred_taken);
        end
        resolve(1'b1);
        compared++;
        if ({mispredict, bp_taken_vld, bp_taken, bp_pc} !== 13'b111_0101010101 || mispredict_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL misp_pulse: got mp=%b vld=%b tk=%b pc=%h cnt=%0d expected 1 1 1 155 1",
                     mispredict, bp_taken_vld, bp_taken, bp_pc, mispredict_cnt);
        end
        step();
        compared++;
        if (mispredict !== 1'b0 || mispredict_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL misp_once: got mp=%b cnt=%0d expected 0 1", mispredict, mispredict_cnt);
        end
        wait_idle(ok);
        compared++;
        if (!ok || bp_pc !== 10'h155) begin
            mismatched++;
            $display("FAIL misp_idle: got ok=%b pc=%h expected ok=1 pc=155", ok, bp_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] pcs [5];
        bit ok;
        pcs[0] = 10'h011; pcs[1] = 10'h022; pcs[2] = 10'h033; pcs[3] = 10'h044; pcs[4] = 10'h3C5;
        forced_pred = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_pc    = pcs[i];
            compared++;
            if (req_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready);
            end
            step();
        end
        req_pc = 10'h3FF;
        compared++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_full: got ready=%b busy=%b expected 0 1", req_ready, busy);
        end
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_pred(ok);
            compared++;
            if (!ok || bp_pc !== pcs[i]) begin
                mismatched++;
                $display("FAIL b2b_order[%0d]: got ok=%b pc=%h expected ok=1 pc=%h", i, ok, bp_pc, pcs[i]);
            end
            resolve(i[0]);
            compared++;
            if ({bp_taken_vld, bp_taken, bp_pc} !== {1'b1, i[0], pcs[i]} || mispredict !== !i[0]) begin
                mismatched++;
                $display("FAIL b2b_update[%0d]: got vld=%b tk=%b pc=%h mp=%b expected 1 %b %h %b",
                         i, bp_taken_vld, bp_taken, bp_pc, mispredict, i[0], pcs[i], !i[0]);
            end
        end
        wait_idle(ok);
        compared++;
        if (!ok || mispredict_cnt !== 16'd4 || mispredict_cnt_s !== 2'd3 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_end: got ok=%b cnt=%0d cnt_s=%0d ready=%b expected 1 4 3 1",
                     ok, mispredict_cnt, mispredict_cnt_s, req_ready);
        end
    endtask

    task automatic test_learning();
        bit ok;
        use_model = 1'b1;
        for (int it = 0; it < 20; it++) begin
            push(10'h000);
            wait_pred(ok);
            compared++;
            if (!ok || pred_taken !== (it != 0)) begin
                mismatched++;
                $display("FAIL learn_pred[%0d]: got ok=%b pt=%b expected ok=1 pt=%b", it, ok, pred_taken, it != 0);
            end
            resolve(1'b1);
            wait_idle(ok);
        end
        compared++;
        if (mispredict_cnt !== 16'd5) begin
            mismatched++;
            $display("FAIL learn_cnt: got %0d expected 5", mispredict_cnt);
        end
        use_model = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        forced_pred = 1'b1;
        push(10'h0AB);
        push(10'h0CD);
        wait_pred(ok);
        resolve(1'b1);
        step();
        compared++;
        if (!ok || bp_taken_vld !== 1'b1 || bp_pc !== 10'h0AB) begin
            mismatched++;
            $display("FAIL rmid_pre: got ok=%b vld=%b pc=%h expected 1 1 0ab", ok, bp_taken_vld, bp_pc);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if ({bp_taken_vld, bp_taken, busy, req_ready, bp_pc} !== 14'b0001_0000000000 || mispredict_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL rmid_async: got vld=%b tk=%b busy=%b ready=%b pc=%h cnt=%0d expected 0 0 0 1 000 0",
                     bp_taken_vld, bp_taken, busy, req_ready, bp_pc, mispredict_cnt);
        end
        step();
        step();
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        compared++;
        if ({bp_taken_vld, busy, pred_valid, req_ready} !== 4'b0001) begin
            mismatched++;
            $display("FAIL rmid_after: got vld=%b busy=%b pv=%b ready=%b expected 0 0 0 1",
                     bp_taken_vld, busy, pred_valid, req_ready);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        forced_pred = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(10'(i));
            wait_pred(ok);
            resolve(1'b1);
            compared++;
            if (!ok || mispredict !== 1'b1 || mispredict_cnt !== 16'(i + 1) ||
                mispredict_cnt_s !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin
                mismatched++;
                $display("FAIL sat[%0d]: got ok=%b mp=%b cnt=%0d cnt_s=%0d expected 1 1 %0d %0d",
                         i, ok, mispredict, mispredict_cnt, mispredict_cnt_s, i + 1, (i + 1 > 3) ? 3 : i + 1);
            end
            wait_idle(ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mispredict();
        test_back_to_back();
        test_learning();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
